// File: rtl/sopc_be_mem_stream_writer.sv
// -----------------------------------------------------------------------------
// sopc_be_mem_stream_writer
//
// Avalon-ST sink to Avalon-MM write master for a single-port on-chip memory.
// On an accepted start, it writes word_count stream words to consecutive memory
// words beginning at base_addr. The address wraps from MEM_WORDS-1 to 0. When
// the transfer ends, done pulses for one cycle.
//
// Optional feature macro: WRITE_VERIFY_EN
//   When defined, a VERIFY pass follows the writes. It re-reads the same words
//   and compares the sum of the read data with the sum of the written data.
//   The result is reported on verify_err.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle transfer request (ignored unless idle)
//   base_addr, word_count first word address / number of words, sampled on start
//   busy, done            transfer in progress / one-cycle completion pulse
//   snk_data/valid/ready  Avalon-ST sink (ready is registered)
//   m_address, m_byteenable, m_chipselect, m_write, m_writedata
//                         Avalon-MM master towards the memory
//   m_readdata            memory read data (WRITE_VERIFY_EN only)
//   verify_err            checksum mismatch flag (WRITE_VERIFY_EN only)
// -----------------------------------------------------------------------------
module sopc_be_mem_stream_writer #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 10000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     word_count,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_W-1:0]     snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata
`ifdef WRITE_VERIFY_EN
    ,
    input  logic [DATA_W-1:0]     m_readdata,
    output logic                  verify_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
`ifdef WRITE_VERIFY_EN
        VERIFY = 2'd2,
`endif
        FIN    = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(MEM_WORDS - 1)) return '0;
        return a + ADDR_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic                arm_q;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   wr_cnt_q;
    logic [DATA_W-1:0]   skid_q [2];
    logic [1:0]          occ_q, occ_d;
    logic                start_ok, accept, pop, push_slot, ready_d;
`ifdef WRITE_VERIFY_EN
    logic [DATA_W-1:0]   wsum_q, rsum_q;
    logic [ADDR_W-1:0]   rd_addr_q, rd_cnt_q, rx_cnt_q;
    logic                rd_vld_p1;
    logic                issue, last_rx;
`endif

    always_comb begin
        // A start in the first cycle after reset release is ignored via arm_q.
        start_ok  = start && arm_q && (state_q == IDLE);
        accept    = snk_valid && snk_ready;
        pop       = (state_q == RUN) && (occ_q != 2'd0);
        occ_d     = occ_q + {1'b0, accept} - {1'b0, pop};
        // The incoming beat lands behind whatever remains after this cycle's pop.
        push_slot = ((occ_q - {1'b0, pop}) == 2'd1);
        count_d   = start_ok ? word_count : count_q;
        acc_d     = start_ok ? '0 : acc_q + ADDR_W'(accept);
`ifdef WRITE_VERIFY_EN
        issue     = (state_q == VERIFY) && (rd_cnt_q != count_q);
        last_rx   = rd_vld_p1 && (rx_cnt_q == count_q - ADDR_W'(1));
`endif

        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = (word_count == '0) ? FIN : RUN;
            // wr_cnt_q reaches count_q in the cycle the last write is on the bus.
`ifdef WRITE_VERIFY_EN
            RUN:    if (wr_cnt_q == count_q) state_d = VERIFY;
            VERIFY: if (last_rx) state_d = FIN;
`else
            RUN:    if (wr_cnt_q == count_q) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered ready: look ahead at next-cycle count and occupancy so that
        // no beat beyond word_count can ever be accepted.
        ready_d = (state_d == RUN) && (acc_d < count_d) && (occ_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q        <= 1'b0;
            snk_ready    <= 1'b0;
            count_q      <= '0;
            acc_q        <= '0;
            occ_q        <= '0;
            wr_addr_q    <= '0;
            wr_cnt_q     <= '0;
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
`ifdef WRITE_VERIFY_EN
            wsum_q       <= '0;
            rsum_q       <= '0;
            rd_addr_q    <= '0;
            rd_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            rd_vld_p1    <= 1'b0;
            verify_err   <= 1'b0;
`endif
        end else begin
            arm_q        <= 1'b1;
            snk_ready    <= ready_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            occ_q        <= occ_d;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;

            if (start_ok) begin
                wr_addr_q  <= base_addr;
                wr_cnt_q   <= '0;
`ifdef WRITE_VERIFY_EN
                wsum_q     <= '0;
                rsum_q     <= '0;
                rd_addr_q  <= base_addr;
                rd_cnt_q   <= '0;
                rx_cnt_q   <= '0;
                verify_err <= 1'b0;
`endif
            end

            // Write stage: pop the head of the skid buffer onto the bus.
            if (pop) begin
                skid_q[0]    <= skid_q[1];
                m_chipselect <= 1'b1;
                m_write      <= 1'b1;
                m_address    <= wr_addr_q;
                m_writedata  <= skid_q[0];
                wr_addr_q    <= next_addr(wr_addr_q);
                wr_cnt_q     <= wr_cnt_q + ADDR_W'(1);
`ifdef WRITE_VERIFY_EN
                wsum_q       <= wsum_q + skid_q[0];
`endif
            end
            if (accept) skid_q[push_slot] <= snk_data;

`ifdef WRITE_VERIFY_EN
            // Read issue stage.
            if (issue) begin
                m_chipselect <= 1'b1;
                m_address    <= rd_addr_q;
                rd_addr_q    <= next_addr(rd_addr_q);
                rd_cnt_q     <= rd_cnt_q + ADDR_W'(1);
            end
            // Read return stage: data is valid one cycle after the address.
            rd_vld_p1 <= m_chipselect && !m_write;
            if (rd_vld_p1) begin
                rsum_q   <= rsum_q + m_readdata;
                rx_cnt_q <= rx_cnt_q + ADDR_W'(1);
                if (last_rx) verify_err <= ((rsum_q + m_readdata) != wsum_q);
            end
`endif
        end
    end

`ifdef WRITE_VERIFY_EN
    assign busy = (state_q == RUN) || (state_q == VERIFY);
`else
    assign busy = (state_q == RUN);
`endif
    assign done         = (state_q == FIN);
    assign m_byteenable = {(DATA_W/8){m_chipselect}};

endmodule

// File: tb/tb_sopc_be_mem_stream_writer.sv
`timescale 1ns/1ps
module tb_sopc_be_mem_stream_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [13:0] word_count = '0;
    logic        busy, done;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [13:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write;
    logic [31:0] m_writedata;
`ifdef WRITE_VERIFY_EN
    logic [31:0] m_readdata;
    logic        verify_err;
    bit          corrupt = 1'b0;
    logic        done_verr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] mem [0:9999];

    logic [13:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_be   [$];
    int          wq_cyc  [$];
    logic [13:0] rq_addr [$];
    int          cs_cnt = 0;
    int          acc_total = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;

    sopc_be_mem_stream_writer #(.ADDR_W(14), .DATA_W(32), .MEM_WORDS(10000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .snk_data     (snk_data),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata)
`ifdef WRITE_VERIFY_EN
        ,
        .m_readdata   (m_readdata),
        .verify_err   (verify_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: synchronous write, 1-cycle read latency.
    always @(posedge clk)
        if (reset_n && m_chipselect && m_write && m_address < 14'd10000)
            mem[m_address] <= m_writedata;
`ifdef WRITE_VERIFY_EN
    always @(posedge clk)
        m_readdata <= (m_address < 14'd10000) ?
                      (mem[m_address] ^ ((corrupt && m_address == 14'd2) ? 32'h1 : 32'h0)) : 32'h0;
`endif

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_chipselect && m_write) begin
                wq_addr.push_back(m_address);
                wq_data.push_back(m_writedata);
                wq_be.push_back(m_byteenable);
                wq_cyc.push_back(cyc);
            end
            if (m_chipselect && !m_write) rq_addr.push_back(m_address);
            if (m_chipselect) cs_cnt++;
            if (snk_valid && snk_ready) acc_total++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef WRITE_VERIFY_EN
                done_verr = verify_err;
`endif
            end
        end
    end

    task automatic do_start(input int base, input int cnt);
        base_addr  = 14'(base);
        word_count = 14'(cnt);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic drive_beats(input logic [31:0] d [8], input int n, input int budget,
                               output int na);
        bit acc;
        na = 0;
        for (int t = 0; t < budget && na < n; t++) begin
            snk_valid = 1'b1;
            snk_data  = d[na];
            @(negedge clk);
            acc = snk_ready;
            @(posedge clk); #1;
            if (acc) na++;
        end
        snk_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        logic [31:0] d [8];
        logic [63:0] outs;
        int d0, w0, na;
        bit ok;
        d = '{32'hC0, 32'hC1, 0, 0, 0, 0, 0, 0};
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        outs = {busy, done, snk_ready, m_chipselect, m_write, m_address, m_writedata, m_byteenable};
        tests++;
        if (outs !== 64'h0) begin fails++; $display("FAIL reset_idle: outputs=%h required 0", outs); end

        // Start in the same cycle reset is released must be ignored.
        base_addr = 14'd7; word_count = 14'd1; start = 1'b1; reset_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_start: busy=%b required 0", busy); end
        repeat (2) @(posedge clk); #1;

        // Reset during RUN with a write on the bus.
        d0 = done_cnt;
        do_start(40, 3);
        snk_valid = 1'b1; snk_data = 32'hDEAD;
        @(posedge clk); #1;
        snk_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (m_write !== 1'b1) begin fails++; $display("FAIL reset_run_pre: m_write=%b required 1", m_write); end
        reset_n = 1'b0;
        #1;
        outs = {busy, done, snk_ready, m_chipselect, m_write, m_address, m_writedata, m_byteenable};
        tests++;
        if (outs !== 64'h0) begin fails++; $display("FAIL reset_run: outputs=%h required 0", outs); end
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        tests++;
        if (done_cnt !== d0) begin fails++; $display("FAIL reset_no_done: done pulses=%0d required 0", done_cnt - d0); end

        // Normal transfer after reset.
        d0 = done_cnt; w0 = wq_addr.size();
        do_start(0, 2);
        drive_beats(d, 2, 10, na);
        wait_done(d0, 30, ok);
        tests++;
        if (!ok || wq_addr.size() - w0 != 2) begin
            fails++; $display("FAIL reset_after_run: done=%b writes=%0d required done=1 writes=2", ok, wq_addr.size() - w0);
        end else begin
            tests++;
            if ({wq_addr[w0], wq_addr[w0+1], wq_data[w0], wq_data[w0+1]} !== {14'd0, 14'd1, 32'hC0, 32'hC1}) begin
                fails++; $display("FAIL reset_after_data: addr=%0d,%0d data=%h,%h required 0,1 c0,c1",
                                  wq_addr[w0], wq_addr[w0+1], wq_data[w0], wq_data[w0+1]);
            end
        end
    endtask

    task automatic test_full_rate();
        logic [31:0] d [8];
        int d0, w0, s, na;
        bit ok;
        d = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
        d0 = done_cnt; w0 = wq_addr.size();
        do_start(5, 4);
        s = cyc;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL full_busy: busy=%b required 1", busy); end
        drive_beats(d, 4, 20, na);
        wait_done(d0, 30, ok);
        tests++;
        if (!ok || wq_addr.size() - w0 != 4) begin
            fails++; $display("FAIL full_count: done=%b writes=%0d required done=1 writes=4", ok, wq_addr.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wq_addr[w0+i] !== 14'(5 + i) || wq_data[w0+i] !== d[i] || wq_be[w0+i] !== 4'hF
                    || wq_cyc[w0+i] !== s + 2 + i) begin
                    fails++;
                    $display("FAIL full_write%0d: addr=%0d data=%h be=%h cyc=%0d required addr=%0d data=%h be=f cyc=%0d",
                             i, wq_addr[w0+i], wq_data[w0+i], wq_be[w0+i], wq_cyc[w0+i] - s, 5 + i, d[i], 2 + i);
                end
            end
`ifndef WRITE_VERIFY_EN
            tests++;
            if (done_cyc !== wq_cyc[w0+3] + 1) begin
                fails++; $display("FAIL full_done_time: done at +%0d required +%0d", done_cyc - s, wq_cyc[w0+3] + 1 - s);
            end
`endif
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d [8];
        int d0, w0, na;
        bit ok;
        d = '{32'hA0, 32'hA1, 32'hA2, 0, 0, 0, 0, 0};
        d0 = done_cnt; w0 = wq_addr.size();
        do_start(9998, 3);
        drive_beats(d, 3, 20, na);
        wait_done(d0, 30, ok);
        tests++;
        if (!ok || wq_addr.size() - w0 != 3) begin
            fails++; $display("FAIL wrap_count: done=%b writes=%0d required done=1 writes=3", ok, wq_addr.size() - w0);
        end else begin
            tests++;
            if ({wq_addr[w0], wq_addr[w0+1], wq_addr[w0+2]} !== {14'd9998, 14'd9999, 14'd0}) begin
                fails++; $display("FAIL wrap_addr: %0d,%0d,%0d required 9998,9999,0", wq_addr[w0], wq_addr[w0+1], wq_addr[w0+2]);
            end
        end
        tests++;
        if (mem[0] !== 32'hA2 || mem[9999] !== 32'hA1) begin
            fails++; $display("FAIL wrap_mem: mem[0]=%h mem[9999]=%h required a2 a1", mem[0], mem[9999]);
        end
    endtask

    task automatic test_count0();
        int d0, c0, s;
        d0 = done_cnt; c0 = cs_cnt;
        do_start(50, 0);
        s = cyc;
        do_start(100, 0);   // sampled in the FIN cycle
        repeat (4) @(posedge clk); #1;
        tests++;
        if (done_cnt - d0 !== 1 || done_cyc !== s) begin
            fails++; $display("FAIL count0_done: pulses=%0d at +%0d required 1 at +0", done_cnt - d0, done_cyc - s);
        end
        tests++;
        if (cs_cnt !== c0) begin fails++; $display("FAIL count0_bus: chipselect cycles=%0d required 0", cs_cnt - c0); end
    endtask

    task automatic test_busy_start();
        logic [31:0] d [8];
        int d0, w0, na;
        bit ok;
        d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 0, 0, 0};
        d0 = done_cnt; w0 = wq_addr.size();
        do_start(20, 2);
        do_start(100, 5);   // busy: must be ignored
        drive_beats(d, 4, 12, na);
        wait_done(d0, 30, ok);
        tests++;
        if (!ok || na !== 2 || wq_addr.size() - w0 != 2) begin
            fails++; $display("FAIL busy_start_count: done=%b accepted=%0d writes=%0d required 1 2 2",
                              ok, na, wq_addr.size() - w0);
        end else begin
            tests++;
            if ({wq_addr[w0], wq_addr[w0+1]} !== {14'd20, 14'd21}) begin
                fails++; $display("FAIL busy_start_addr: %0d,%0d required 20,21", wq_addr[w0], wq_addr[w0+1]);
            end
        end
    endtask

    task automatic test_gappy();
        logic [31:0] d [8];
        int d0, w0, a0, na;
        bit acc, six, checked, ok;
        d = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66, 32'h67};
        d0 = done_cnt; w0 = wq_addr.size(); a0 = acc_total;
        na = 0; six = 1'b0; checked = 1'b0;
        do_start(200, 6);
        for (int t = 0; t < 30; t++) begin
            snk_valid = (t % 2 == 0);
            snk_data  = d[(na < 8) ? na : 7];
            @(negedge clk);
            acc = snk_valid && snk_ready;
            if (six && !checked) begin
                checked = 1'b1;
                tests++;
                if (snk_ready !== 1'b0) begin fails++; $display("FAIL gappy_ready: snk_ready=%b after 6th beat required 0", snk_ready); end
            end
            @(posedge clk); #1;
            if (acc) begin
                na++;
                if (na == 6) six = 1'b1;
            end
        end
        snk_valid = 1'b0;
        wait_done(d0, 30, ok);
        tests++;
        if (!ok || na !== 6 || acc_total - a0 !== 6 || wq_addr.size() - w0 != 6) begin
            fails++; $display("FAIL gappy_count: done=%b accepted=%0d/%0d writes=%0d required 1 6/6 6",
                              ok, na, acc_total - a0, wq_addr.size() - w0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (wq_addr[w0+i] !== 14'(200 + i) || wq_data[w0+i] !== d[i]) begin
                    fails++; $display("FAIL gappy_write%0d: addr=%0d data=%h required %0d %h",
                                      i, wq_addr[w0+i], wq_data[w0+i], 200 + i, d[i]);
                end
            end
        end
    endtask

`ifdef WRITE_VERIFY_EN
    task automatic test_verify();
        logic [31:0] d [8];
        int d0, r0, na;
        bit ok;
        d = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 0, 0, 0, 0};
        corrupt = 1'b0;
        d0 = done_cnt; r0 = rq_addr.size();
        do_start(0, 4);
        drive_beats(d, 4, 20, na);
        wait_done(d0, 40, ok);
        tests++;
        if (!ok || rq_addr.size() - r0 != 4) begin
            fails++; $display("FAIL verify_reads: done=%b reads=%0d required 1 4", ok, rq_addr.size() - r0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (rq_addr[r0+i] !== 14'(i)) begin fails++; $display("FAIL verify_raddr%0d: %0d required %0d", i, rq_addr[r0+i], i); end
            end
        end
        tests++;
        if (done_verr !== 1'b0) begin fails++; $display("FAIL verify_clean: verify_err=%b required 0", done_verr); end

        corrupt = 1'b1;
        d0 = done_cnt;
        do_start(0, 4);
        drive_beats(d, 4, 20, na);
        wait_done(d0, 40, ok);
        tests++;
        if (!ok || done_verr !== 1'b1) begin fails++; $display("FAIL verify_corrupt: done=%b verify_err=%b required 1 1", ok, done_verr); end
        corrupt = 1'b0;
        do_start(0, 0);
        tests++;
        if (verify_err !== 1'b0) begin fails++; $display("FAIL verify_clear: verify_err=%b required 0", verify_err); end
        repeat (3) @(posedge clk); #1;
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_rate();
        test_wrap();
        test_count0();
        test_busy_start();
        test_gappy();
`ifdef WRITE_VERIFY_EN
        test_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
